// File: rtl/sprite_fetch_if.sv
// Sprite fetch bus: ROM read port plus the downstream pixel stream.
// The master side is the fetch engine; the slave side is ROM + pixel sink.
interface sprite_fetch_if #(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 3
);
  localparam int X_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int Y_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pix;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;
  logic              out_last;

  modport master (
    output rom_addr,
    input  rom_q,
    output out_valid,
    input  out_ready,
    output out_pix,
    output out_x,
    output out_y,
    output out_last
  );

  modport slave (
    input  rom_addr,
    output rom_q,
    input  out_valid,
    output out_ready,
    input  out_pix,
    input  out_x,
    input  out_y,
    input  out_last
  );
endinterface

// File: rtl/sprite_fetch.sv
// Sprite fetch engine: streams one SPR_W x SPR_H sprite from a synchronous
// ROM (one-cycle read latency) in raster order, optionally mirrored in X,
// through a 2-entry skid FIFO so downstream back-pressure never loses data.
module sprite_fetch #(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 3
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic           flip_x,
  output logic           busy,
  output logic           done,
  sprite_fetch_if.master bus
);
  localparam int X_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int Y_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int ENT_W = DATA_W + X_W + Y_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t         state;
  logic           flip;
  logic [X_W-1:0] col;
  logic [Y_W-1:0] row;
  logic [X_W-1:0] col_m;

  logic           vld_p1;
  logic [X_W-1:0] tag_x_p1;
  logic [Y_W-1:0] tag_y_p1;
  logic           tag_last_p1;

  logic [ENT_W-1:0] fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic [ENT_W-1:0] head;

  logic col_end, row_end, last_issue, issue, push, pop;

  assign col_end    = (col == X_W'(SPR_W - 1));
  assign row_end    = (row == Y_W'(SPR_H - 1));
  assign last_issue = col_end && row_end;
  assign pop        = bus.out_valid && bus.out_ready;
  assign push       = vld_p1;
  // Issue only if the FIFO can absorb this read after accounting for the
  // read already in flight and the pop happening this cycle.
  assign issue      = (state == FETCH) &&
                      ((3'(occ) + 3'(vld_p1)) < (3'd2 + 3'(pop)));

  assign busy = (state != IDLE);
  assign done = (state == DRAIN) && pop && bus.out_last;

  // ---- stage p0: address generation from the raster counters ----
  // ROM address: mirrored column in flip mode, zero outside FETCH.
  always_comb begin
    col_m        = flip ? (X_W'(SPR_W - 1) - col) : col;
    bus.rom_addr = '0;
    if (state == FETCH)
      bus.rom_addr = ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col_m);
  end

  // Control FSM: accepts start, walks col/row per issued read, drains FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      flip  <= 1'b0;
      col   <= '0;
      row   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            flip  <= flip_x;
            col   <= '0;
            row   <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            if (col_end) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && bus.out_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: read in flight, tag travels with the ROM access ----
  // In-flight valid marks that rom_q carries data on the next edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= issue;
  end

  // Unmirrored coordinates of the outstanding read.
  always_ff @(posedge clock) begin
    if (issue) begin
      tag_x_p1    <= col;
      tag_y_p1    <= row;
      tag_last_p1 <= last_issue;
    end
  end

  // ---- stage p2: skid FIFO feeding the output stream ----
  // FIFO pointers and occupancy; push and pop together keep occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage: ROM word joined with its coordinate tag.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {bus.rom_q, tag_x_p1, tag_y_p1, tag_last_p1};
  end

  // Output view of the FIFO head, forced to zero while empty.
  always_comb begin
    head          = fifo_mem[rd_ptr];
    bus.out_valid = (occ != 2'd0);
    bus.out_pix   = '0;
    bus.out_x     = '0;
    bus.out_y     = '0;
    bus.out_last  = 1'b0;
    if (bus.out_valid) begin
      bus.out_pix  = head[ENT_W-1 -: DATA_W];
      bus.out_x    = head[X_W+Y_W -: X_W];
      bus.out_y    = head[Y_W -: Y_W];
      bus.out_last = head[0];
    end
  end
endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: expected pixels are queued at start,
// a forked monitor pops and compares on every accepted output beat.
module tb_sprite_fetch;
  logic clock = 1'b0;
  logic reset_n;
  logic start;
  logic flip_x;
  logic busy;
  logic done;

  sprite_fetch_if #(.SPR_W(32), .SPR_H(32), .ADDR_W(10), .DATA_W(3)) sif ();

  sprite_fetch #(.SPR_W(32), .SPR_H(32), .ADDR_W(10), .DATA_W(3)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .flip_x (flip_x),
    .busy   (busy),
    .done   (done),
    .bus    (sif)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] rom_fn(input logic [9:0] a);
    return a[2:0] ^ a[5:3] ^ {1'b0, a[9:8]};
  endfunction

  // Synchronous ROM model, one-cycle read latency.
  always @(posedge clock) sif.rom_q <= rom_fn(sif.rom_addr);

  typedef struct packed {
    logic [2:0] pix;
    logic [4:0] x;
    logic [4:0] y;
    logic       last;
  } exp_t;

  exp_t  q[$];
  exp_t  e;
  int    tests = 0;
  int    fails = 0;
  int    pop_cnt = 0;
  int    done_cnt = 0;
  int    pbase = 0;
  int    dbase = 0;
  logic  prev_stall = 1'b0;
  logic [13:0] prev_out = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic f);
    exp_t ex;
    int   addr;
    @(posedge clock); #1;
    start  = 1'b1;
    flip_x = f;
    pbase  = pop_cnt;
    dbase  = done_cnt;
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 32; x++) begin
        addr    = y * 32 + (f ? 31 - x : x);
        ex.pix  = rom_fn(10'(addr));
        ex.x    = 5'(x);
        ex.y    = 5'(y);
        ex.last = (x == 31) && (y == 31);
        q.push_back(ex);
      end
    end
    @(posedge clock); #1;
    start  = 1'b0;
    flip_x = 1'b0;
  endtask

  task automatic finish_sprite(input int mode);
    int n;
    n = 0;
    while (busy && n < 6000) begin
      @(posedge clock); #1;
      if (mode == 1) sif.out_ready = ($urandom_range(0, 9) < 3);
      n++;
    end
    chk("sprite_timeout", 64'(busy), 64'd0);
    chk("queue_empty", 64'(q.size()), 64'd0);
    chk("pixel_count", 64'(pop_cnt - pbase), 64'd1024);
    chk("done_count", 64'(done_cnt - dbase), 64'd1);
    sif.out_ready = 1'b1;
  endtask

  initial begin
    int err;
    int n;
    reset_n       = 1'b0;
    start         = 1'b0;
    flip_x        = 1'b0;
    sif.out_ready = 1'b1;

    fork
      forever begin
        @(negedge clock);
        if (!reset_n) begin
          prev_stall = 1'b0;
          continue;
        end
        if (prev_stall)
          chk("hold_stable", {sif.out_valid, sif.out_pix, sif.out_x, sif.out_y, sif.out_last},
              {1'b1, prev_out});
        if (sif.out_valid && sif.out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_pixel", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("pixel_%0d", pop_cnt - pbase),
                {sif.out_pix, sif.out_x, sif.out_y, sif.out_last}, e);
            chk("done_align", 64'(done), 64'(e.last));
          end
          pop_cnt++;
        end else if (done) begin
          chk("spurious_done", 64'd1, 64'd0);
        end
        if (done) done_cnt++;
        prev_stall = sif.out_valid && !sif.out_ready;
        prev_out   = {sif.out_pix, sif.out_x, sif.out_y, sif.out_last};
      end
    join_none

    #12;
    chk("reset_state", {busy, done, sif.out_valid, sif.rom_addr, sif.out_pix,
                        sif.out_x, sif.out_y, sif.out_last}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Plain raster, full-rate sink: address sequence and first-pixel latency.
    do_start(1'b0);
    err = 0;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clock);
      if (sif.rom_addr !== 10'(k)) err++;
      if (k == 0) chk("busy_after_start", 64'(busy), 64'd1);
      if (k == 1) chk("valid_low_after_e1", 64'(sif.out_valid), 64'd0);
      if (k == 2) chk("valid_high_after_e2", 64'(sif.out_valid), 64'd1);
    end
    chk("addr_seq_flip0", 64'(err), 64'd0);
    finish_sprite(0);

    // Mirrored fetch: addresses reversed per row, coordinates not.
    do_start(1'b1);
    err = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (sif.rom_addr !== 10'((k / 32) * 32 + 31 - (k % 32))) err++;
    end
    chk("addr_seq_flip1", 64'(err), 64'd0);
    finish_sprite(0);

    // Sink ready at roughly 30% duty.
    do_start(1'b0);
    finish_sprite(1);

    // Sink stalled for 10 cycles from first valid.
    @(posedge clock); #1;
    sif.out_ready = 1'b0;
    do_start(1'b0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!sif.out_valid && n < 10);
    chk("first_valid_cycle", 64'(n), 64'd3);
    err = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clock);
      if (sif.rom_addr !== 10'd2) err++;
    end
    chk("stall_addr_frozen", 64'(err), 64'd0);
    @(posedge clock); #1;
    sif.out_ready = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(negedge clock);
      n++;
      if (done) break;
    end
    chk("resume_no_gap", 64'(n), 64'd1024);
    finish_sprite(0);

    // Second start mid-sprite must be ignored.
    do_start(1'b0);
    n = 0;
    while ((pop_cnt - pbase) < 100 && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    start  = 1'b1;
    flip_x = 1'b1;
    @(posedge clock); #1;
    start  = 1'b0;
    flip_x = 1'b0;
    finish_sprite(0);

    // Asynchronous reset mid-sprite, then a fresh sprite from address 0.
    do_start(1'b0);
    n = 0;
    while ((pop_cnt - pbase) < 500 && n < 1000) begin
      @(posedge clock); #1;
      n++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_midop", {busy, done, sif.out_valid, sif.rom_addr, sif.out_pix,
                        sif.out_x, sif.out_y, sif.out_last}, 64'd0);
    q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    err = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (busy || sif.out_valid) err++;
    end
    chk("idle_after_reset", 64'(err), 64'd0);
    do_start(1'b0);
    err = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (sif.rom_addr !== 10'(k)) err++;
    end
    chk("restart_addr", 64'(err), 64'd0);
    finish_sprite(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
